// File: rtl/interboard_receiver.sv
// interboard_receiver
// Receive side of the 4-phase Request/Ack link between the two boards.
// Request and interboard_data are synchronised, and each word is captured only after Request has
// been stable for a settle window. Six words make one message for GameControl. At word index 0
// the value 6'h3F is a remote-reset command.
// Optional feature macro: RECV_TIMEOUT_EN. When it is defined, a partially received message is
// abandoned after TIMEOUT_CYCLES idle cycles between words.
// Handshake: Ack rises only after a word has been captured, and it stays high until Request is
// seen low. A new word is never accepted while Ack is high.
module interboard_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Request,
    input  logic [5:0] interboard_data,
    output logic       Ack,
    output logic       msg_valid,
    output logic [3:0] msg_type,
    output logic [4:0] msg_block_x,
    output logic [2:0] msg_block_y,
    output logic [5:0] msg_card,
    output logic [2:0] msg_sel_len,
    output logic       msg_move_dir,
    output logic       remote_rst,
    output logic       timeout_err,
    output logic [1:0] o_dbg_state
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACK_HI = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [5:0]             r_data_sync [SYNC_STAGES];
    logic                   w_req_s;
    logic [5:0]             w_data_s;

    state_t                 r_state;
    logic [SCW-1:0]         r_settle_cnt;
    logic [2:0]             r_idx;
    logic                   r_ack;
    logic                   w_capture;

    logic [3:0]             r_sh_type;
    logic [4:0]             r_sh_x;
    logic [2:0]             r_sh_y;
    logic [5:0]             r_sh_card;
    logic [2:0]             r_sh_sel;

    logic                   r_msg_valid;
    logic [3:0]             r_msg_type;
    logic [4:0]             r_msg_x;
    logic [2:0]             r_msg_y;
    logic [5:0]             r_msg_card;
    logic [2:0]             r_msg_sel;
    logic                   r_msg_dir;
    logic                   r_remote_rst;

`ifdef RECV_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0]         r_to_cnt;
    logic                   r_timeout_err;
`endif

    // Synchronise Request and the data bus through the same number of stages.
    // The sender keeps the data stable while Request is high, and the settle window covers any
    // skew between the two chains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= 6'd0;
        end else begin
            r_req_sync     <= {r_req_sync[SYNC_STAGES-2:0], Request};
            r_data_sync[0] <= interboard_data;
            for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
        end
    end

    assign w_req_s  = r_req_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];

    // A word is taken on the last cycle of an unbroken settle window.
    assign w_capture = (r_state == S_SETTLE) && w_req_s &&
                       (r_settle_cnt == SCW'(SETTLE_CYCLES - 1));

    // Handshake FSM, word assembly and the registered message and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_idx        <= 3'd0;
            r_ack        <= 1'b0;
            r_sh_type    <= 4'd0;
            r_sh_x       <= 5'd0;
            r_sh_y       <= 3'd0;
            r_sh_card    <= 6'd0;
            r_sh_sel     <= 3'd0;
            r_msg_valid  <= 1'b0;
            r_msg_type   <= 4'd0;
            r_msg_x      <= 5'd0;
            r_msg_y      <= 3'd0;
            r_msg_card   <= 6'd0;
            r_msg_sel    <= 3'd0;
            r_msg_dir    <= 1'b0;
            r_remote_rst <= 1'b0;
`ifdef RECV_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_msg_valid  <= 1'b0;
            r_remote_rst <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (w_req_s) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (!w_req_s) begin
                        r_state <= S_IDLE;
                    end else if (w_capture) begin
                        r_state <= S_ACK_HI;
                        r_ack   <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SCW'(1);
                    end
                end
                S_ACK_HI: begin
                    if (!w_req_s) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase

`ifdef RECV_TIMEOUT_EN
            // This is evaluated before the capture logic, so a capture wins any
            // assignment to r_idx made in the same cycle.
            r_timeout_err <= 1'b0;
            if (w_capture) begin
                r_to_cnt <= '0;
            end else if (r_state == S_IDLE && r_idx != 3'd0) begin
                if (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
                    r_to_cnt      <= '0;
                    r_idx         <= 3'd0;
                    r_timeout_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TOW'(1);
                end
            end
`endif

            if (w_capture) begin
                if (r_idx == 3'd0 && w_data_s == 6'h3F) begin
                    r_remote_rst <= 1'b1;
                end else begin
                    case (r_idx)
                        3'd0: r_sh_type <= w_data_s[3:0];
                        3'd1: r_sh_x    <= w_data_s[4:0];
                        3'd2: r_sh_y    <= w_data_s[2:0];
                        3'd3: r_sh_card <= w_data_s;
                        3'd4: r_sh_sel  <= w_data_s[2:0];
                        default: begin
                            r_msg_type  <= r_sh_type;
                            r_msg_x     <= r_sh_x;
                            r_msg_y     <= r_sh_y;
                            r_msg_card  <= r_sh_card;
                            r_msg_sel   <= r_sh_sel;
                            r_msg_dir   <= w_data_s[0];
                            r_msg_valid <= 1'b1;
                        end
                    endcase
                    r_idx <= (r_idx >= 3'd5) ? 3'd0 : r_idx + 3'd1;
                end
            end
        end
    end

    assign Ack          = r_ack;
    assign msg_valid    = r_msg_valid;
    assign msg_type     = r_msg_type;
    assign msg_block_x  = r_msg_x;
    assign msg_block_y  = r_msg_y;
    assign msg_card     = r_msg_card;
    assign msg_sel_len  = r_msg_sel;
    assign msg_move_dir = r_msg_dir;
    assign remote_rst   = r_remote_rst;
    assign o_dbg_state  = r_state;
`ifdef RECV_TIMEOUT_EN
    assign timeout_err  = r_timeout_err;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_interboard_receiver.sv
// Bench for interboard_receiver: table vectors, hand-written corner sequences and random traffic
// checked against a word-level message model.
module tb_interboard_receiver;

  localparam int SYNC  = 2;
  localparam int SETL  = 4;
  localparam int TOUT  = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Request = 1'b0;
  logic [5:0] interboard_data = 6'd0;
  logic       Ack, msg_valid, msg_move_dir, remote_rst, timeout_err;
  logic [3:0] msg_type;
  logic [4:0] msg_block_x;
  logic [2:0] msg_block_y, msg_sel_len;
  logic [5:0] msg_card;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  interboard_receiver #(
    .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETL), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .Request(Request), .interboard_data(interboard_data),
    .Ack(Ack), .msg_valid(msg_valid), .msg_type(msg_type), .msg_block_x(msg_block_x),
    .msg_block_y(msg_block_y), .msg_card(msg_card), .msg_sel_len(msg_sel_len),
    .msg_move_dir(msg_move_dir), .remote_rst(remote_rst), .timeout_err(timeout_err),
    .o_dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int fails = 0;
  logic [21:0] exp_q[$];
  int exp_rr = 0;
  int ack_rises = 0;
  int msg_seen = 0;
  int rr_seen = 0;
  int to_seen = 0;
  logic prev_ack = 1'b0;
  logic prev_mv = 1'b0;

  // reference model: word index and collected words of the message in progress
  int m_idx = 0;
  logic [5:0] m_w[6];
  logic [21:0] last_msg = 22'd0;

  function automatic logic [21:0] got_msg();
    return {msg_type, msg_block_x, msg_block_y, msg_card, msg_sel_len, msg_move_dir};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_word(input logic [5:0] d);
    logic [21:0] m;
    if (m_idx == 0 && d == 6'h3F) begin
      exp_rr++;
    end else begin
      m_w[m_idx] = d;
      m_idx++;
      if (m_idx == 6) begin
        m = {m_w[0][3:0], m_w[1][4:0], m_w[2][2:0], m_w[3], m_w[4][2:0], m_w[5][0]};
        exp_q.push_back(m);
        last_msg = m;
        m_idx = 0;
      end
    end
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    logic [21:0] e;
    if (Ack === 1'b1 && prev_ack !== 1'b1) ack_rises++;
    prev_ack = Ack;
    if (msg_valid === 1'b1) begin
      msg_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected msg_valid: got %0h expected none", got_msg());
      end else begin
        e = exp_q.pop_front();
        check("msg payload", {10'd0, got_msg()}, {10'd0, e});
      end
      check("msg_valid one cycle", {31'd0, prev_mv}, 32'd0);
      check("msg_valid/remote_rst exclusive", {31'd0, remote_rst}, 32'd0);
    end
    prev_mv = msg_valid;
    if (remote_rst === 1'b1) begin
      rr_seen++;
      checks++;
      if (exp_rr == 0) begin
        fails++;
        $display("FAIL unexpected remote_rst: got 1 expected 0");
      end else begin
        exp_rr--;
      end
    end
    if (timeout_err === 1'b1) to_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input logic lvl);
    int n;
    n = 0;
    while (Ack !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (Ack !== lvl) begin
      checks++;
      fails++;
      $display("FAIL ack wait: got %b expected %b", Ack, lvl);
    end
  endtask

  task automatic send_word(input logic [5:0] d);
    wait_ack(1'b0);
    model_word(d);
    @(negedge clk);
    interboard_data = d;
    Request = 1'b1;
    wait_ack(1'b1);
    @(negedge clk);
    Request = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    Request = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_idx = 0;
    last_msg = 22'd0;
  endtask

  task automatic glitch(input logic [5:0] d);
    int r0;
    r0 = ack_rises;
    @(negedge clk);
    interboard_data = d;
    Request = 1'b1;
    repeat (2) @(negedge clk);
    Request = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch no ack", ack_rises, r0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0] w[6];
    logic [3:0] t;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c;
    logic [2:0] s;
    logic       d;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int cyc;
    int r0;
    int m0;
    tbl[0].w = '{6'h03, 6'h0A, 6'h05, 6'h21, 6'h02, 6'h01};
    tbl[0].t = 4'd3;  tbl[0].x = 5'd10; tbl[0].y = 3'd5; tbl[0].c = 6'd33; tbl[0].s = 3'd2; tbl[0].d = 1'b1;
    tbl[1].w = '{6'h01, 6'h1F, 6'h07, 6'h3F, 6'h07, 6'h00};
    tbl[1].t = 4'd1;  tbl[1].x = 5'd31; tbl[1].y = 3'd7; tbl[1].c = 6'd63; tbl[1].s = 3'd7; tbl[1].d = 1'b0;
    tbl[2].w = '{6'h2F, 6'h3F, 6'h3E, 6'h00, 6'h3D, 6'h3E};
    tbl[2].t = 4'd15; tbl[2].x = 5'd31; tbl[2].y = 3'd6; tbl[2].c = 6'd0;  tbl[2].s = 3'd5; tbl[2].d = 1'b0;
    tbl[3].w = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    tbl[3].t = 4'd0;  tbl[3].x = 5'd0;  tbl[3].y = 3'd0; tbl[3].c = 6'd0;  tbl[3].s = 3'd0; tbl[3].d = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset outputs", {28'd0, Ack, msg_valid, remote_rst, timeout_err}, 32'd0);
    check("reset msg fields", {10'd0, got_msg()}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // first message, with latency measured on word 0
    ack_rises = 0;
    model_word(6'h03);
    interboard_data = 6'h03;
    Request = 1'b1;
    cyc = 0;
    while (Ack !== 1'b1 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("req->ack latency", cyc, SYNC + SETL + 1);
    @(negedge clk);
    Request = 1'b0;
    cyc = 0;
    while (Ack !== 1'b0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("req fall->ack low latency", cyc, SYNC + 1);
    for (int j = 1; j < 6; j++) send_word(tbl[0].w[j]);
    repeat (2) @(negedge clk);
    check("ack toggles", ack_rises, 6);
    check("msg count", msg_seen, 1);
    check("msg_type", {28'd0, msg_type}, {28'd0, tbl[0].t});
    check("msg_card", {26'd0, msg_card}, {26'd0, tbl[0].c});

    // table vectors
    for (int i = 0; i < 4; i++) begin
      r0 = rr_seen;
      for (int j = 0; j < 6; j++) send_word(tbl[i].w[j]);
      @(negedge clk);
      check("tbl msg_type", {28'd0, msg_type}, {28'd0, tbl[i].t});
      check("tbl msg_block_x", {27'd0, msg_block_x}, {27'd0, tbl[i].x});
      check("tbl msg_block_y", {29'd0, msg_block_y}, {29'd0, tbl[i].y});
      check("tbl msg_card", {26'd0, msg_card}, {26'd0, tbl[i].c});
      check("tbl msg_sel_len", {29'd0, msg_sel_len}, {29'd0, tbl[i].s});
      check("tbl msg_move_dir", {31'd0, msg_move_dir}, {31'd0, tbl[i].d});
      check("tbl no remote_rst", rr_seen, r0);
    end

    // remote reset with Request held high
    r0 = rr_seen;
    m0 = msg_seen;
    wait_ack(1'b0);
    model_word(6'h3F);
    @(negedge clk);
    interboard_data = 6'h3F;
    Request = 1'b1;
    wait_ack(1'b1);
    repeat (40) @(negedge clk);
    check("ack held during remote reset", {31'd0, Ack}, 32'd1);
    check("remote_rst pulse count", rr_seen, r0 + 1);
    Request = 1'b0;
    wait_ack(1'b0);
    check("no msg on remote reset", msg_seen, m0);
    for (int j = 0; j < 6; j++) send_word(tbl[0].w[j]);
    @(negedge clk);
    check("after remote reset msg_type", {28'd0, msg_type}, 32'd3);
    check("after remote reset msg_block_x", {27'd0, msg_block_x}, 32'd10);

    // short Request pulse, then a message proves index unchanged
    glitch(6'h15);
    for (int j = 0; j < 6; j++) send_word(tbl[2].w[j]);
    @(negedge clk);
    check("after glitch msg", {10'd0, got_msg()}, {10'd0, last_msg});

    // three words then rst (asserted while Ack is high)
    m0 = msg_seen;
    send_word(6'h09);
    send_word(6'h11);
    @(negedge clk);
    interboard_data = 6'h22;
    Request = 1'b1;
    wait_ack(1'b1);
    @(negedge clk);
    rst = 1'b1;
    Request = 1'b0;
    @(posedge clk);
    #1;
    check("ack low after rst", {31'd0, Ack}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_idx = 0;
    last_msg = 22'd0;
    repeat (4) @(negedge clk);
    check("no msg after partial+rst", msg_seen, m0);
    check("fields cleared by rst", {10'd0, got_msg()}, 32'd0);
    for (int j = 0; j < 6; j++) send_word(tbl[1].w[j]);
    @(negedge clk);
    check("msg after rst", {10'd0, got_msg()}, {10'd0, last_msg});

`ifdef RECV_TIMEOUT_EN
    // two words, then a long idle gap
    r0 = to_seen;
    send_word(6'h04);
    send_word(6'h05);
    repeat (TOUT + 30) @(negedge clk);
    check("timeout_err pulse", to_seen, r0 + 1);
    m_idx = 0;
    for (int j = 0; j < 6; j++) send_word(tbl[0].w[j]);
    @(negedge clk);
    check("msg after timeout", {10'd0, got_msg()}, {10'd0, last_msg});
`endif

    // random traffic
    for (int k = 0; k < 60; k++) begin
      int op;
      op = $urandom_range(0, 11);
      if (op == 0) begin
        glitch(6'($urandom_range(0, 63)));
      end else if (op == 1) begin
        do_reset();
        repeat (2) @(negedge clk);
        check("rand rst fields", {10'd0, got_msg()}, 32'd0);
      end else if (op <= 3) begin
        send_word(6'h3F);
      end else begin
        send_word(6'($urandom_range(0, 63)));
      end
      @(negedge clk);
      check("rand held msg", {10'd0, got_msg()}, {10'd0, last_msg});
    end
    while (m_idx != 0) send_word(6'($urandom_range(0, 62)));
    repeat (4) @(negedge clk);
    check("final held msg", {10'd0, got_msg()}, {10'd0, last_msg});

    check("exp queue drained", exp_q.size(), 0);
    check("remote_rst expectations met", exp_rr, 0);
`ifndef RECV_TIMEOUT_EN
    check("timeout_err never asserted", to_seen, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
